timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Programmable period/repeat timer controller that sequences one `counter` instance through its `load`/`enable`/`dir` controls. A requester starts it with a period P and repeat count N. It emits a one-cycle `tick` at the end of every period and a `done` pulse after the N-th period, with `pause` and `stop` control. It sits between software-visible timer registers and the shared `counter` datapath.

## Interface
- `COUNTER_SIZE`, 32, width of the counter, `period` and `cnt_val`
- `REP_W`, 8, width of `repeat_n` and of the internal period counter
- `clk`  in  1  single clock, all logic on rising edge
- `res`  in  1  reset; synchronous and active-high
- `start`  in  1  pulse; sampled only in IDLE
- `stop`  in  1  abort; returns to IDLE in any state
- `pause`  in  1  level; freezes counting while in RUN
- `dir_cfg`  in  1  0 = count up 0..P-1, 1 = count down P-1..0
- `period`  in  COUNTER_SIZE  P, in cycles; latched on accepted `start`
- `repeat_n`  in  REP_W  N periods; 0 = run until `stop`; latched on accepted `start`
- `busy`  out  1  high when state is not IDLE
- `tick`  out  1  one-cycle pulse per completed period
- `done`  out  1  one-cycle pulse when the N-th period completes
- `err`  out  1  one-cycle pulse on a rejected `start`
- `cnt_val`  out  COUNTER_SIZE  `counter` `cnt_out` passthrough

## Operation
- States: IDLE, ARM, RUN. Reset puts the block in IDLE, with `busy`/`tick`/`done`/`err` at 0 and the period counter at 0. `counter.res_n` is driven by `~res`, so `cnt_val` = 0.
- Priority: `res` > `stop` > `start`.
- IDLE:
  - `start` with `period` != 0: latch P, N and dir, clear the period counter, go to ARM.
  - `start` with `period` == 0: set `err`, stay in IDLE.
  - `counter` enable = 0 and load = 0.
- ARM: assert `load` for exactly one cycle with `cnt_in` = 0 (up) or P-1 (down), then go to RUN. `pause` is ignored in ARM.
- RUN, `pause` = 0, not terminal: enable = 1, with `dir` taken from the latched `dir_cfg`.
- Terminal value is P-1 when counting up and 0 when counting down.
- RUN at terminal:
  - Register `tick`.
  - If N = 0, or the period count + 1 < N: assert `load` (reload the start value), increment the period count, stay in RUN.
  - Otherwise register `done`, go to IDLE, and leave the counter holding the terminal value.
- RUN, `pause` = 1: enable = 0, load = 0, no terminal action, and `cnt_val` holds. `busy` stays 1.
- `stop` in ARM or RUN: go to IDLE next cycle. No `tick` or `done` is produced, even if that cycle was terminal. The counter holds its value.
- `start` in ARM or RUN is ignored and pulses `err`. With `stop` asserted in the same cycle, `stop` wins and there is no `err`.
- `period`, `repeat_n` and `dir_cfg` changes while `busy` have no effect.
- When N = 0 the period counter does not increment, so there is no wrap.
- The `counter` `overflow` output is unused. `counter` `load` must have priority over `enable` and take effect on the next edge.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: ARM, `busy` = 1.
- Cycle 2: RUN, `cnt_val` = start value.
- First `tick` in cycle P+2; subsequent ticks every P cycles, each delayed by the number of paused cycles.
- P = 1: `tick` every cycle from cycle 3 onward.
- N-th period: `tick` = `done` = 1 in cycle N·P+2, and `busy` = 0 in that same cycle.
- `err` is high in the cycle after the rejected `start`.
- `stop` sampled in cycle k: `busy` = 0 in cycle k+1.
- `res` mid-operation: all outputs return to their reset values on the next edge.

## Structure
- Package `timer_ctrl_pkg`:
  - `state_t` enum {IDLE, ARM, RUN}
  - constants `DIR_UP` = 1'b0, `DIR_DOWN` = 1'b1
- One sub-module: the existing `counter`, instantiated as `counter_I` with `counter_size` = COUNTER_SIZE.
- Controller FSM, latch registers and period counter live in `timer_ctrl`.

## Test plan
- P = 5, N = 3, up, `start` in cycle 0: `tick` in cycles 7, 12, 17; `done` and `busy` = 0 in cycle 17; `cnt_val` cycles 0..4.
- P = 4, N = 0, down: `cnt_val` runs 3, 2, 1, 0, 3…; ticks every 4 cycles; after `stop`, `busy` = 0 next cycle with no further ticks.
- P = 6, N = 1, `pause` high for 3 cycles from cycle 4: `tick` and `done` in cycle 11 instead of 8, and `cnt_val` frozen during the pause.
- `start` with `period` = 0: `err` = 1 for one cycle and `busy` stays 0. A second `start` while busy: `err` pulses and the running period count is unaffected.
- P = 1, N = 4: `tick` in cycles 3..6, `done` in cycle 6.
- `res` asserted mid-RUN: next cycle `busy` = 0, `cnt_val` = 0, no `tick`; a following `start` behaves as from reset.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the period/repeat timer controller.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/timer_ctrl_counter.sv
// Loadable up/down counter shared with the timer controller.
// Load has priority over enable; both act on the next rising edge.
module counter
  import timer_ctrl_pkg::*;
#(
  parameter int counter_size = 32
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic                    dir,
  input  logic [counter_size-1:0] cnt_in,
  output logic [counter_size-1:0] cnt_out,
  output logic                    overflow
);

  // Count register with synchronous active-low clear, load over enable
  always_ff @(posedge clk) begin
    if (!res_n) begin
      cnt_out  <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      cnt_out  <= cnt_in;
      overflow <= 1'b0;
    end else if (enable) begin
      if (dir == DIR_UP) begin
        cnt_out  <= cnt_out + 1'b1;
        overflow <= &cnt_out;
      end else begin
        cnt_out  <= cnt_out - 1'b1;
        overflow <= (cnt_out == '0);
      end
    end else begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Period/repeat timer controller: sequences the shared counter through
// load/enable/dir, emitting a tick per period and done after N periods.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int COUNTER_SIZE = 32,
  parameter int REP_W        = 8
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    pause,
  input  logic                    dir_cfg,
  input  logic [COUNTER_SIZE-1:0] period,
  input  logic [REP_W-1:0]        repeat_n,
  output logic                    busy,
  output logic                    tick,
  output logic                    done,
  output logic                    err,
  output logic [COUNTER_SIZE-1:0] cnt_val
);

  state_t                  state_q, state_d;
  logic [COUNTER_SIZE-1:0] period_q;
  logic [REP_W-1:0]        rep_q;
  logic                    dir_q;
  logic [REP_W-1:0]        pcount_q;

  logic                    tick_d, done_d, err_d;
  logic                    latch, pcount_inc;
  logic                    cnt_load, cnt_en;
  logic [COUNTER_SIZE-1:0] start_val, term_val;
  logic [REP_W:0]          pcount_next;
  logic                    more;
  logic                    at_term;
  logic                    ovf_unused;

  // Start value and terminal value depend only on the latched direction
  assign start_val   = (dir_q == DIR_DOWN) ? (period_q - 1'b1) : '0;
  assign term_val    = (dir_q == DIR_DOWN) ? '0 : (period_q - 1'b1);
  assign at_term     = (cnt_val == term_val);
  // One bit wider so the +1 never wraps before comparing against N
  assign pcount_next = {1'b0, pcount_q} + {{REP_W{1'b0}}, 1'b1};
  assign more        = (rep_q == '0) || (pcount_next < {1'b0, rep_q});
  assign busy        = (state_q != IDLE);

  // Next-state, counter controls and registered-pulse requests
  always_comb begin
    state_d    = state_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    latch      = 1'b0;
    pcount_inc = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stop && start) begin
          if (period != '0) begin
            latch   = 1'b1;
            state_d = ARM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ARM: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          cnt_load = 1'b1;
          state_d  = RUN;
          err_d    = start;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          err_d = start;
          if (!pause) begin
            if (at_term) begin
              tick_d = 1'b1;
              if (more) begin
                cnt_load   = 1'b1;
                // With N = 0 the period count stays put, so it never wraps
                pcount_inc = (rep_q != '0);
              end else begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and output pulse registers
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      tick    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      tick    <= tick_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  // Period counter: cleared on accepted start, advanced on each reload
  always_ff @(posedge clk) begin
    if (res) begin
      pcount_q <= '0;
    end else if (latch) begin
      pcount_q <= '0;
    end else if (pcount_inc) begin
      pcount_q <= pcount_q + 1'b1;
    end
  end

  // Configuration captured on accepted start; ignored while busy
  always_ff @(posedge clk) begin
    if (latch) begin
      period_q <= period;
      rep_q    <= repeat_n;
      dir_q    <= dir_cfg;
    end
  end

  counter #(
    .counter_size(COUNTER_SIZE)
  ) counter_I (
    .clk     (clk),
    .res_n   (~res),
    .enable  (cnt_en),
    .load    (cnt_load),
    .dir     (dir_q),
    .cnt_in  (start_val),
    .cnt_out (cnt_val),
    .overflow(ovf_unused)
  );

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: cycle-by-cycle checks against
// hand-derived tick/done/busy/err/cnt_val sequences.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic        dir_cfg = 1'b0;
  logic [31:0] period = '0;
  logic [7:0]  repeat_n = '0;
  logic        busy, tick, done, err;
  logic [31:0] cnt_val;

  int n_checks = 0;
  int n_fail   = 0;

  timer_ctrl #(.COUNTER_SIZE(32), .REP_W(8)) dut (
    .clk     (clk),
    .res     (res),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .dir_cfg (dir_cfg),
    .period  (period),
    .repeat_n(repeat_n),
    .busy    (busy),
    .tick    (tick),
    .done    (done),
    .err     (err),
    .cnt_val (cnt_val)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start in "cycle 0", return positioned in cycle 1 with the
  // configuration inputs scrambled to show they were latched.
  task automatic kick(input logic [31:0] p, input logic [7:0] n, input logic d);
    start    = 1'b1;
    period   = p;
    repeat_n = n;
    dir_cfg  = d;
    step();
    start    = 1'b0;
    period   = 32'd99;
    repeat_n = 8'd200;
    dir_cfg  = ~d;
  endtask

  task automatic test_reset();
    res = 1'b1;
    step();
    step();
    n_checks++;
    if ({busy, tick, done, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, tick, done, err});
    end
    n_checks++;
    if (cnt_val !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d expected 0", cnt_val);
    end
    res = 1'b0;
    step();
    n_checks++;
    if ({busy, tick, done, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle_flags: got %b expected 0000", {busy, tick, done, err});
    end
    n_checks++;
    if (cnt_val !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_idle_cnt: got %0d expected 0", cnt_val);
    end
  endtask

  task automatic test_up_repeat();
    logic [3:0]  ef;
    logic [31:0] ec;
    kick(32'd5, 8'd3, 1'b0);
    for (int c = 1; c <= 19; c++) begin
      if (c > 1) step();
      ef = {(c <= 16), (c == 7 || c == 12 || c == 17), (c == 17), 1'b0};
      n_checks++;
      if ({busy, tick, done, err} !== ef) begin
        n_fail++;
        $display("FAIL up_flags c%0d: got %b expected %b", c, {busy, tick, done, err}, ef);
      end
      if (c >= 2) begin
        ec = (c <= 16) ? 32'((c - 2) % 5) : 32'd4;
        n_checks++;
        if (cnt_val !== ec) begin
          n_fail++;
          $display("FAIL up_cnt c%0d: got %0d expected %0d", c, cnt_val, ec);
        end
      end
    end
  endtask

  task automatic test_down_stop();
    logic [3:0]  ef;
    logic [31:0] ec;
    kick(32'd4, 8'd0, 1'b1);
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) step();
      ef = {1'b1, (c == 6 || c == 10), 1'b0, 1'b0};
      n_checks++;
      if ({busy, tick, done, err} !== ef) begin
        n_fail++;
        $display("FAIL down_flags c%0d: got %b expected %b", c, {busy, tick, done, err}, ef);
      end
      if (c >= 2) begin
        ec = 32'd3 - 32'((c - 2) % 4);
        n_checks++;
        if (cnt_val !== ec) begin
          n_fail++;
          $display("FAIL down_cnt c%0d: got %0d expected %0d", c, cnt_val, ec);
        end
      end
    end
    // Stop on a terminal cycle, with a simultaneous start that must not err
    stop   = 1'b1;
    start  = 1'b1;
    period = 32'd9;
    step();
    stop  = 1'b0;
    start = 1'b0;
    for (int c = 14; c <= 17; c++) begin
      if (c > 14) step();
      n_checks++;
      if ({busy, tick, done, err} !== 4'b0000) begin
        n_fail++;
        $display("FAIL stop_flags c%0d: got %b expected 0000", c, {busy, tick, done, err});
      end
      n_checks++;
      if (cnt_val !== 32'd0) begin
        n_fail++;
        $display("FAIL stop_cnt c%0d: got %0d expected 0", c, cnt_val);
      end
    end
  endtask

  task automatic test_pause();
    logic [3:0]  ef;
    logic [31:0] ec;
    kick(32'd6, 8'd1, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) step();
      pause = (c >= 4 && c <= 6);
      ef = {(c <= 10), (c == 11), (c == 11), 1'b0};
      n_checks++;
      if ({busy, tick, done, err} !== ef) begin
        n_fail++;
        $display("FAIL pause_flags c%0d: got %b expected %b", c, {busy, tick, done, err}, ef);
      end
      if (c >= 2) begin
        ec = (c <= 3) ? 32'(c - 2) : (c <= 7) ? 32'd2 : (c <= 10) ? 32'(c - 5) : 32'd5;
        n_checks++;
        if (cnt_val !== ec) begin
          n_fail++;
          $display("FAIL pause_cnt c%0d: got %0d expected %0d", c, cnt_val, ec);
        end
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_err();
    logic [3:0]  ef;
    logic [31:0] ec;
    start    = 1'b1;
    period   = 32'd0;
    repeat_n = 8'd3;
    step();
    start = 1'b0;
    n_checks++;
    if ({busy, tick, done, err} !== 4'b0001) begin
      n_fail++;
      $display("FAIL zero_period_err: got %b expected 0001", {busy, tick, done, err});
    end
    step();
    n_checks++;
    if ({busy, tick, done, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL zero_period_after: got %b expected 0000", {busy, tick, done, err});
    end
    kick(32'd3, 8'd2, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) step();
      start = (c == 3);
      if (c == 3) period = 32'd7;
      ef = {(c <= 7), (c == 5 || c == 8), (c == 8), (c == 4)};
      n_checks++;
      if ({busy, tick, done, err} !== ef) begin
        n_fail++;
        $display("FAIL busy_start_flags c%0d: got %b expected %b", c, {busy, tick, done, err}, ef);
      end
      if (c >= 2) begin
        ec = (c <= 7) ? 32'((c - 2) % 3) : 32'd2;
        n_checks++;
        if (cnt_val !== ec) begin
          n_fail++;
          $display("FAIL busy_start_cnt c%0d: got %0d expected %0d", c, cnt_val, ec);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_period_one();
    logic [3:0] ef;
    kick(32'd1, 8'd4, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) step();
      ef = {(c <= 5), (c >= 3 && c <= 6), (c == 6), 1'b0};
      n_checks++;
      if ({busy, tick, done, err} !== ef) begin
        n_fail++;
        $display("FAIL p1_flags c%0d: got %b expected %b", c, {busy, tick, done, err}, ef);
      end
      if (c >= 2) begin
        n_checks++;
        if (cnt_val !== 32'd0) begin
          n_fail++;
          $display("FAIL p1_cnt c%0d: got %0d expected 0", c, cnt_val);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0]  ef;
    logic [31:0] ec;
    kick(32'd5, 8'd0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) step();
      n_checks++;
      if ({busy, tick, done, err} !== 4'b1000) begin
        n_fail++;
        $display("FAIL mid_pre_flags c%0d: got %b expected 1000", c, {busy, tick, done, err});
      end
      if (c >= 2) begin
        n_checks++;
        if (cnt_val !== 32'(c - 2)) begin
          n_fail++;
          $display("FAIL mid_pre_cnt c%0d: got %0d expected %0d", c, cnt_val, c - 2);
        end
      end
    end
    // Reset lands on the terminal cycle: the tick must be suppressed
    res = 1'b1;
    step();
    res = 1'b0;
    for (int c = 7; c <= 8; c++) begin
      if (c > 7) step();
      n_checks++;
      if ({busy, tick, done, err} !== 4'b0000) begin
        n_fail++;
        $display("FAIL mid_rst_flags c%0d: got %b expected 0000", c, {busy, tick, done, err});
      end
      n_checks++;
      if (cnt_val !== 32'd0) begin
        n_fail++;
        $display("FAIL mid_rst_cnt c%0d: got %0d expected 0", c, cnt_val);
      end
    end
    kick(32'd2, 8'd1, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) step();
      ef = {(c <= 3), (c == 4), (c == 4), 1'b0};
      ec = (c >= 3) ? 32'd1 : 32'd0;
      n_checks++;
      if ({busy, tick, done, err} !== ef) begin
        n_fail++;
        $display("FAIL post_rst_flags c%0d: got %b expected %b", c, {busy, tick, done, err}, ef);
      end
      n_checks++;
      if (cnt_val !== ec) begin
        n_fail++;
        $display("FAIL post_rst_cnt c%0d: got %0d expected %0d", c, cnt_val, ec);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_up_repeat();
    test_down_stop();
    test_pause();
    test_err();
    test_period_one();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
